// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

   // Default word-address and data widths
   localparam int DEF_AW = 30;
   localparam int DEF_DW = 32;

   // Memory access direction encoding
   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   // Which port, if any, owns the read data returning this cycle
   typedef enum logic [1:0] {
      RESP_NONE = 2'd0,
      RESP_I    = 2'd1,
      RESP_D    = 2'd2
   } resp_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive cycles the instruction port asked and was
// refused. at_limit tells the arbiter to push the instruction port ahead.
module mem_arb_starve_cnt #(
   parameter int LIMIT = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_req,
   input  logic i_gnt,
   output logic at_limit
);
   localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   // Count denied instruction cycles; any grant or idle cycle restarts the count
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         cnt <= '0;
      else if (!i_req || i_gnt)
         cnt <= '0;
      else if (cnt != CW'(LIMIT))
         cnt <= cnt + CW'(1);
   end

   assign at_limit = (cnt == CW'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single-access-per-cycle memory.
// Data has priority; a starved instruction port is forced through after
// STARVE_LIMIT refused cycles. Read data returns one cycle after the grant.
// Optional stall statistics are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW           = DEF_AW,
   parameter int DW           = DEF_DW,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          I_REQ,
   input  logic [AW-1:0] I_ADDR,
   output logic          I_GNT,
   output logic          I_VALID,
   output logic [DW-1:0] I_RDATA,
   input  logic          D_REQ,
   input  logic          D_RW,
   input  logic [AW-1:0] D_ADDR,
   input  logic [DW-1:0] D_WDATA,
   output logic          D_GNT,
   output logic          D_VALID,
   output logic [DW-1:0] D_RDATA,
   output logic          M_REQ,
   output logic          M_RW,
   output logic [AW-1:0] M_ADDR,
   output logic [DW-1:0] M_WDATA,
   input  logic [DW-1:0] M_RDATA
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]   STAT_ISTALL,
   output logic [31:0]   STAT_DSTALL
`endif
);

   logic  starved;
   resp_e resp_q;

   mem_arb_starve_cnt #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .CLK      (CLK),
      .RST      (RST),
      .i_req    (I_REQ),
      .i_gnt    (I_GNT),
      .at_limit (starved)
   );

   // Pick the winner: data first unless the instruction port has starved
   always_comb begin
      I_GNT = 1'b0;
      D_GNT = 1'b0;
      if (!RST) begin
         if (I_REQ && (starved || !D_REQ))
            I_GNT = 1'b1;
         else if (D_REQ)
            D_GNT = 1'b1;
      end
   end

   // Steer the granted port onto the memory bus; idle bus is all zeros
   always_comb begin
      M_REQ   = I_GNT | D_GNT;
      M_RW    = RW_READ;
      M_ADDR  = '0;
      M_WDATA = '0;
      if (I_GNT) begin
         M_ADDR  = I_ADDR;
      end else if (D_GNT) begin
         M_RW    = D_RW;
         M_ADDR  = D_ADDR;
         M_WDATA = D_WDATA;
      end
   end

   // Remember which port owns next cycle's read data; reset drops it
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         resp_q <= RESP_NONE;
      else if (I_GNT)
         resp_q <= RESP_I;
      else if (D_GNT && (D_RW == RW_READ))
         resp_q <= RESP_D;
      else
         resp_q <= RESP_NONE;
   end

   // Route returning data to its owner only; the other side sees zero
   always_comb begin
      I_VALID = (resp_q == RESP_I);
      D_VALID = (resp_q == RESP_D);
      I_RDATA = I_VALID ? M_RDATA : '0;
      D_RDATA = D_VALID ? M_RDATA : '0;
   end

`ifdef MEM_ARB_STATS_EN
   // Saturating counts of refused request cycles per port
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         STAT_ISTALL <= '0;
         STAT_DSTALL <= '0;
      end else begin
         if (I_REQ && !I_GNT && (STAT_ISTALL != '1))
            STAT_ISTALL <= STAT_ISTALL + 32'd1;
         if (D_REQ && !D_GNT && (STAT_DSTALL != '1))
            STAT_DSTALL <= STAT_DSTALL + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory responder returns address-derived
// data, expected read data is queued at grant time and popped on VALID.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW  = 30;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          I_REQ = 1'b0, D_REQ = 1'b0, D_RW = RW_READ;
   logic [AW-1:0] I_ADDR = '0, D_ADDR = '0;
   logic [DW-1:0] D_WDATA = '0, M_RDATA = '0;
   logic          I_GNT, I_VALID, D_GNT, D_VALID, M_REQ, M_RW;
   logic [DW-1:0] I_RDATA, D_RDATA, M_WDATA;
   logic [AW-1:0] M_ADDR;
`ifdef MEM_ARB_STATS_EN
   logic [31:0]   STAT_ISTALL, STAT_DSTALL;
`endif

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
      .CLK(CLK), .RST(RST),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_VALID(I_VALID), .I_RDATA(I_RDATA),
      .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_GNT(D_GNT), .D_VALID(D_VALID), .D_RDATA(D_RDATA),
      .M_REQ(M_REQ), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_RDATA(M_RDATA)
`ifdef MEM_ARB_STATS_EN
      , .STAT_ISTALL(STAT_ISTALL), .STAT_DSTALL(STAT_DSTALL)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Memory contents as seen by the responder; address 0x10 holds 0xDEADBEEF
   function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
      logic [AW-1:0] off;
      off = a - AW'(16);
      return 32'hDEADBEEF ^ (DW'(off) * 32'h0100_0193);
   endfunction

   // Memory: read data one cycle after a read strobe, junk otherwise
   always @(posedge CLK) begin
      if (M_REQ && (M_RW == RW_READ))
         M_RDATA <= mem_fn(M_ADDR);
      else
         M_RDATA <= $urandom;
   end

   // Reference model and scoreboard, sampled mid-cycle
   logic [DW-1:0] iq[$];
   logic [DW-1:0] dq[$];
   int            exp_cnt = 0;
   logic [31:0]   exp_ist = '0, exp_dst = '0;

   always @(negedge CLK) begin : mon
      logic          force_i, eig, edg;
      logic [DW-1:0] v;
      if (RST) begin
         chk("rst_i_gnt", I_GNT, 0);
         chk("rst_d_gnt", D_GNT, 0);
         chk("rst_m_req", M_REQ, 0);
         chk("rst_i_valid", I_VALID, 0);
         chk("rst_d_valid", D_VALID, 0);
         chk("rst_i_rdata", I_RDATA, 0);
         chk("rst_d_rdata", D_RDATA, 0);
         chk("rst_cnt", dut.u_starve.cnt, 0);
`ifdef MEM_ARB_STATS_EN
         chk("rst_stat_i", STAT_ISTALL, 0);
         chk("rst_stat_d", STAT_DSTALL, 0);
`endif
         iq.delete();
         dq.delete();
         exp_cnt = 0;
         exp_ist = '0;
         exp_dst = '0;
      end else begin
         chk("starve_cnt", dut.u_starve.cnt, exp_cnt);
         chk("i_valid", I_VALID, iq.size() != 0);
         if (iq.size() != 0) begin
            v = iq.pop_front();
            chk("i_rdata", I_RDATA, v);
         end else
            chk("i_rdata_idle", I_RDATA, 0);
         chk("d_valid", D_VALID, dq.size() != 0);
         if (dq.size() != 0) begin
            v = dq.pop_front();
            chk("d_rdata", D_RDATA, v);
         end else
            chk("d_rdata_idle", D_RDATA, 0);

         force_i = I_REQ && (exp_cnt == LIM);
         eig     = I_REQ && (force_i || !D_REQ);
         edg     = D_REQ && !eig;
         chk("i_gnt", I_GNT, eig);
         chk("d_gnt", D_GNT, edg);
         chk("m_req", M_REQ, eig | edg);
         if (eig) begin
            chk("m_rw_i", M_RW, RW_READ);
            chk("m_addr_i", M_ADDR, I_ADDR);
            chk("m_wdata_i", M_WDATA, 0);
            iq.push_back(mem_fn(I_ADDR));
         end else if (edg) begin
            chk("m_rw_d", M_RW, D_RW);
            chk("m_addr_d", M_ADDR, D_ADDR);
            chk("m_wdata_d", M_WDATA, D_WDATA);
            if (D_RW == RW_READ)
               dq.push_back(mem_fn(D_ADDR));
         end else begin
            chk("m_idle", {M_RW, M_ADDR, M_WDATA}, 0);
         end

`ifdef MEM_ARB_STATS_EN
         chk("stat_istall", STAT_ISTALL, exp_ist);
         chk("stat_dstall", STAT_DSTALL, exp_dst);
         if (I_REQ && !eig && exp_ist != '1) exp_ist = exp_ist + 1;
         if (D_REQ && !edg && exp_dst != '1) exp_dst = exp_dst + 1;
`endif
         if (!I_REQ || eig)
            exp_cnt = 0;
         else if (exp_cnt < LIM)
            exp_cnt = exp_cnt + 1;
      end
   end

   // Present one cycle of requests, then advance past the next rising edge
   task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                        input logic drw, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
      I_REQ   = ir;
      I_ADDR  = ia;
      D_REQ   = dr;
      D_RW    = drw;
      D_ADDR  = da;
      D_WDATA = dwd;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, RW_READ, '0, '0);
   endtask

   initial begin
      #2 RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;

      // lone instruction read of 0x10, data comes back next cycle
      drive(1'b1, AW'('h10), 1'b0, RW_READ, '0, '0);
      idle();

      // contention: data wins four times, then the starved instruction port
      repeat (5) drive(1'b1, AW'('h14), 1'b1, RW_READ, AW'('h20), '0);
      idle();
      idle();

      // data write produces no VALID
      drive(1'b0, '0, 1'b1, RW_WRITE, AW'('h30), 32'h12345678);
      idle();

      // back-to-back instruction then data read
      drive(1'b1, AW'('h40), 1'b0, RW_READ, '0, '0);
      drive(1'b0, '0, 1'b1, RW_READ, AW'('h50), '0);
      idle();
      idle();

      // reset lands while a data read is in flight
      drive(1'b0, '0, 1'b1, RW_READ, AW'('h60), '0);
      I_REQ = 1'b0;
      D_REQ = 1'b0;
      RST   = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      idle();
      idle();

      // random traffic, biased towards contention
      for (int n = 0; n < 400; n++)
         drive(($urandom % 4) != 0, AW'($urandom), ($urandom % 4) != 0,
               logic'($urandom % 2), AW'($urandom), DW'($urandom));
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 30, word-address width of both request ports and the memory port.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter STARVE_LIMIT, default 4, number of consecutive denied instruction-request cycles before the instruction port is forced ahead of the data port.
REQ-004 Port CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 Port RST  in  1  reset, asynchronous, active-high.
REQ-006 Instruction port: I_REQ in 1 read request; I_ADDR in AW address; I_GNT out 1 request accepted this cycle; I_VALID out 1 read data valid; I_RDATA out DW read data.
REQ-007 Data port: D_REQ in 1 request; D_RW in 1, 1=write, 0=read; D_ADDR in AW address; D_WDATA in DW write data; D_GNT out 1 accepted; D_VALID out 1 read data valid; D_RDATA out DW read data.
REQ-008 Memory port: M_REQ out 1 access strobe; M_RW out 1, 1=write; M_ADDR out AW; M_WDATA out DW; M_RDATA in DW, valid exactly one cycle after a read strobe.

Function
REQ-009 One memory access per cycle; M_REQ = I_GNT | D_GNT; I_GNT and D_GNT never both 1.
REQ-010 Grant is combinational from the current requests and the starvation state; M_RW/M_ADDR/M_WDATA come from the granted port, and are 0 when there is no grant.
REQ-011 Default priority: data over instruction.
REQ-012 Starvation counter: increments each cycle that I_REQ=1 and I_GNT=0; clears on I_GNT=1 or I_REQ=0; saturates at STARVE_LIMIT.
REQ-013 When the counter equals STARVE_LIMIT and I_REQ=1, the instruction port wins that cycle even if D_REQ=1.
REQ-014 A granted read is in flight for one cycle, tracked in a response register with states RESP_NONE, RESP_I and RESP_D.
REQ-015 Response state transitions, taken every edge: I read grant -> RESP_I; D read grant (D_RW=0) -> RESP_D; otherwise -> RESP_NONE.
REQ-016 In RESP_I: I_VALID=1 and I_RDATA=M_RDATA. In RESP_D: D_VALID=1 and D_RDATA=M_RDATA. The non-selected RDATA output is 0.
REQ-017 A write grant produces no VALID pulse; D_GNT alone signals completion.
REQ-018 Read latency is one cycle from GNT to VALID; back-to-back grants are supported every cycle with no bubble.
REQ-019 A requester holds REQ and its address/data until it sees GNT; a REQ dropped before grant is a legal cancel.

Reset
REQ-020 While RST=1: response state is RESP_NONE, the starvation counter is 0, and I_VALID, D_VALID, I_RDATA and D_RDATA are 0.
REQ-021 Grants are forced to 0 while RST=1, so M_REQ=0.
REQ-022 If RST is asserted mid-access, the in-flight read response is discarded: no VALID pulse after reset release.

Configuration
REQ-023 Macro MEM_ARB_STATS_EN defined: add output ports STAT_ISTALL (32 bits) and STAT_DSTALL (32 bits).
REQ-024 STAT_ISTALL counts cycles with I_REQ & ~I_GNT; STAT_DSTALL counts cycles with D_REQ & ~D_GNT; both saturate at all-ones and are cleared by RST.
REQ-025 Macro MEM_ARB_STATS_EN undefined: the STAT ports and counters are absent, and all other behaviour is identical.

Structure
REQ-026 The shared package holds the response-state enum (RESP_NONE, RESP_I, RESP_D), the RW encoding constants and the default AW/DW values.
REQ-027 One sub-module, mem_arb_starve_cnt, implements the saturating starvation counter; the arbiter and response routing stay in mem_arbiter.

Verification
REQ-028 Scenario: I_REQ=1 at I_ADDR=0x10 alone, M_RDATA=0xDEADBEEF next cycle -> I_GNT=1 in cycle 0; I_VALID=1 and I_RDATA=0xDEADBEEF in cycle 1.
REQ-029 Scenario: I_REQ and D_REQ (read, 0x20) both held, STARVE_LIMIT=4 -> D_GNT in cycles 0-3; I_GNT in cycle 4; counter reads 0 in cycle 5.
REQ-030 Scenario: D write at 0x30 with 0x12345678 -> M_RW=1, M_ADDR=0x30, M_WDATA=0x12345678; D_VALID stays 0.
REQ-031 Scenario: I read, then D read in consecutive cycles -> I_VALID in cycle 1 and D_VALID in cycle 2, each carrying its own M_RDATA, with no cross-routing.
REQ-032 Scenario: RST pulsed in the cycle after a D read grant -> D_VALID never asserts; all outputs 0 during reset.
REQ-033 Scenario: with MEM_ARB_STATS_EN, 4 cycles of contention -> STAT_ISTALL=4, STAT_DSTALL=0.
